regfile_wr_sched: RTL

//  Write-port scheduler for a register file built from enable/clear D flip-flops.
//  - Shares the single write port between two requesters, A and B (e.g. ALU writeback, load writeback).
//  - Drives a one-hot per-register enable vector plus the write data.
//  - Runs a zero-fill sweep over all registers on command.
//  - Sits between the CPU writeback stage and the register bank.

---
 rtl/regfile_wr_sched.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/regfile_wr_sched.sv
// Write-port scheduler: round-robin A/B arbitration plus a zero-fill sweep.
// Optional macro WR_ZERO_GUARD_EN: register 0 is hardwired zero.
module regfile_wr_sched #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic                 Clk,
  input  logic                 Clr,
  input  logic                 ReqA,
  input  logic [AW-1:0]        AddrA,
  input  logic [DW-1:0]        DataA,
  output logic                 GntA,
  input  logic                 ReqB,
  input  logic [AW-1:0]        AddrB,
  input  logic [DW-1:0]        DataB,
  output logic                 GntB,
  input  logic                 SweepReq,
  output logic [(2**AW)-1:0]   WrEn,
  output logic [DW-1:0]        WrData,
  output logic                 Busy,
  output logic                 SweepDone
);

  localparam int NREG = 2**AW;

`ifdef WR_ZERO_GUARD_EN
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);
`else
  localparam logic [AW-1:0] FIRST_IDX = '0;
`endif
  localparam logic [AW-1:0] LAST_IDX = '1;

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t          state;
  logic [AW-1:0]   idx;
  logic [AW-1:0]   next_idx;
  logic            pref_b;

  logic            elig_a;
  logic            elig_b;
  logic            pick_a;
  logic            pick_b;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  function automatic logic [NREG-1:0] onehot(
    input logic [AW-1:0] a
  );
    onehot    = '0;
    onehot[a] = 1'b1;
  endfunction

  // Address decode for requester writes; the sweep uses onehot directly.
  function automatic logic [NREG-1:0] decode(
    input logic [AW-1:0] a
  );
    decode = onehot(a);
`ifdef WR_ZERO_GUARD_EN
    if (a == '0) begin
      decode = '0;
    end
`endif
  endfunction

  // A requester granted last edge sits out one edge so a held
  // level request cannot be written twice.
  always_comb begin
    elig_a   = ReqA & ~GntA;
    elig_b   = ReqB & ~GntB;
    pick_a   = elig_a & (~elig_b | ~pref_b);
    pick_b   = elig_b & (~elig_a | pref_b);
    sel_addr = pick_a ? AddrA : AddrB;
    sel_data = pick_a ? DataA : DataB;
    next_idx = idx + AW'(1);
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state     <= IDLE;
      idx       <= '0;
      pref_b    <= 1'b0;
      GntA      <= 1'b0;
      GntB      <= 1'b0;
      WrEn      <= '0;
      WrData    <= '0;
      Busy      <= 1'b0;
      SweepDone <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          SweepDone <= 1'b0;
          if (SweepReq) begin
            state  <= SWEEP;
            idx    <= FIRST_IDX;
            GntA   <= 1'b0;
            GntB   <= 1'b0;
            WrEn   <= onehot(FIRST_IDX);
            WrData <= '0;
            Busy   <= 1'b1;
          end else begin
            GntA <= pick_a;
            GntB <= pick_b;
            if (pick_a | pick_b) begin
              WrEn   <= decode(sel_addr);
              WrData <= sel_data;
              pref_b <= pick_a;
            end else begin
              WrEn <= '0;
            end
          end
        end
        SWEEP: begin
          GntA <= 1'b0;
          GntB <= 1'b0;
          if (idx == LAST_IDX) begin
            state     <= IDLE;
            WrEn      <= '0;
            Busy      <= 1'b0;
            SweepDone <= 1'b1;
          end else begin
            idx  <= next_idx;
            WrEn <= onehot(next_idx);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  a_gnt_excl: assert property (
    @(posedge Clk) !(GntA && GntB)
  );

  a_en_onehot: assert property (
    @(posedge Clk) $onehot0(WrEn)
  );

endmodule
